// File: rtl/data_mem_unit_if.sv
// Bus between the M-stage pipeline register and the data-memory unit.
// The master drives the access; the slave returns load data and error state.
interface data_mem_unit_if;
    logic        mem_write;
    logic        mem_read;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        misaligned;
    logic        err_sticky;
    logic [31:0] err_addr;

    modport master (
        output mem_write, mem_read, funct3, addr, wdata,
        input  rdata, misaligned, err_sticky, err_addr
    );

    modport slave (
        input  mem_write, mem_read, funct3, addr, wdata,
        output rdata, misaligned, err_sticky, err_addr
    );
endinterface

// File: rtl/data_mem_unit.sv
// RV32I data-memory stage: lane-steered stores, zero-latency extended loads,
// plus a small MMIO window (cycle counter, store counter, sticky error capture).
module data_mem_unit #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
    input logic          clk,
    input logic          reset,
    data_mem_unit_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] cycle_q;
    logic [31:0] stcnt_q;
    logic        err_sticky_q;
    logic [31:0] err_addr_q;

    logic          in_mem;
    logic          in_mmio;
    logic          access;
    logic          is_store;
    logic          is_load;
    logic          f3_legal;
    logic          mis_align;
    logic          fault;
    logic          commit;
    logic [1:0]    size;
    logic [5:0]    reg_off;
    logic [AW-1:0] widx;
    logic          mem_we;
    logic          wr_cycle;
    logic          wr_stcnt;
    logic          clr_err;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   rword;
    logic [31:0]   shifted;
    logic [31:0]   ext;

    // ---------------------------------------------------------------
    // Access decode
    // ---------------------------------------------------------------
    assign in_mem   = (bus.addr[31:AW+2] == '0);
    assign in_mmio  = (bus.addr[31:8] == MMIO_BASE[31:8]);
    assign access   = bus.mem_read | bus.mem_write;
    // A store wins if both strobes are ever high together.
    assign is_store = bus.mem_write;
    assign is_load  = bus.mem_read & ~bus.mem_write;
    assign size     = bus.funct3[1:0];
    assign reg_off  = bus.addr[7:2];
    assign widx     = bus.addr[AW+1:2];

    always_comb begin
        f3_legal = 1'b0;
        if (is_store) begin
            f3_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                       (bus.funct3 == 3'b010);
        end else begin
            f3_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                       (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                       (bus.funct3 == 3'b101);
        end
    end

    assign mis_align = ((size == 2'b01) && bus.addr[0]) ||
                       ((size == 2'b10) && (bus.addr[1:0] != 2'b00));
    assign fault     = access & (~f3_legal | mis_align | ~(in_mem | in_mmio));

    assign commit   = is_store & ~fault & ~reset;
    assign mem_we   = commit & in_mem;
    assign wr_cycle = commit & in_mmio & (reg_off == 6'd0) & (size == 2'b10);
    assign wr_stcnt = commit & in_mmio & (reg_off == 6'd1) & (size == 2'b10);
    assign clr_err  = commit & in_mmio & (reg_off == 6'd2);

    // ---------------------------------------------------------------
    // Store lane steering
    // ---------------------------------------------------------------
    always_comb begin
        be    = 4'b0000;
        wword = bus.wdata;
        case (size)
            2'b00: begin
                be    = 4'b0001 << bus.addr[1:0];
                wword = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be    = bus.addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{bus.wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wword = bus.wdata;
            end
        endcase
    end

    // Memory contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // MMIO registers and error capture
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q      <= '0;
            stcnt_q      <= '0;
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            cycle_q <= wr_cycle ? bus.wdata : cycle_q + 32'd1;

            if (wr_stcnt) begin
                stcnt_q <= bus.wdata;
            end else if (mem_we && (stcnt_q != 32'hFFFF_FFFF)) begin
                stcnt_q <= stcnt_q + 32'd1;
            end

            if (clr_err) begin
                err_sticky_q <= 1'b0;
                err_addr_q   <= '0;
            end else if (fault && !err_sticky_q) begin
                err_sticky_q <= 1'b1;
                err_addr_q   <= bus.addr;
            end
        end
    end

    // ---------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------
    always_comb begin
        rword = '0;
        if (in_mem) begin
            rword = mem_q[widx];
        end else if (in_mmio) begin
            case (reg_off)
                6'd0:    rword = cycle_q;
                6'd1:    rword = stcnt_q;
                6'd2:    rword = err_addr_q;
                default: rword = '0;
            endcase
        end
    end

    assign shifted = rword >> {bus.addr[1:0], 3'b000};

    always_comb begin
        ext = '0;
        case (bus.funct3)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  ext = rword;
            3'b100:  ext = {24'b0, shifted[7:0]};
            3'b101:  ext = {16'b0, shifted[15:0]};
            default: ext = '0;
        endcase
    end

    assign bus.rdata      = (is_load && !fault) ? ext : 32'b0;
    assign bus.misaligned = fault;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_addr   = err_addr_q;
endmodule
